// File: rtl/lut_sxx_chain_pkg.sv
// -----------------------------------------------------------------------------
// lut_sxx_chain_pkg
//   Shared types and width helpers for the cascaded configurable LUT chain.
//   - state_t        : configuration load state (UNCFG / LOADING / READY)
//   - calc_aw        : user address width for a given INPUTS / STAGES
//   - calc_mem_size  : truth-table bits per stage
//   - calc_cfg_bits  : total serial config bits (all tables + 1 mode bit)
//   - calc_cnt_w     : width of the config bit counter (must hold CFG_BITS)
// -----------------------------------------------------------------------------
package lut_sxx_chain_pkg;

   typedef enum logic [1:0] {
      UNCFG   = 2'd0,
      LOADING = 2'd1,
      READY   = 2'd2
   } state_t;

   function automatic int calc_aw(input int inputs, input int stages);
      return stages * (inputs - 1) + 1;
   endfunction

   function automatic int calc_mem_size(input int inputs);
      return 1 << inputs;
   endfunction

   function automatic int calc_cfg_bits(input int inputs, input int stages);
      return stages * (1 << inputs) + 1;
   endfunction

   function automatic int calc_cnt_w(input int cfg_bits);
      return $clog2(cfg_bits + 1);
   endfunction

endpackage

// File: rtl/lut_sxx_chain_stage.sv
// -----------------------------------------------------------------------------
// lut_sxx_chain_stage
//   One purely combinational INPUTS-input table lookup.
//   Ports:
//     table_i  [MEM_SIZE-1:0] : truth table, bit n is the result for address n
//     addr_i   [INPUTS-1:0]   : lookup address
//     bit_o                   : table_i[addr_i]
// -----------------------------------------------------------------------------
module lut_sxx_chain_stage
   import lut_sxx_chain_pkg::*;
#(
   parameter int INPUTS   = 4,
   parameter int MEM_SIZE = calc_mem_size(INPUTS)
) (
   input  logic [MEM_SIZE-1:0] table_i,
   input  logic [INPUTS-1:0]   addr_i,
   output logic                bit_o
);

   always_comb begin
      bit_o = table_i[addr_i];
   end

endmodule

// File: rtl/lut_sxx_chain_cfg.sv
// -----------------------------------------------------------------------------
// lut_sxx_chain_cfg
//   STAGES cascaded INPUTS-input LUTs with an on-block serial configuration
//   loader. Each stage after the first uses the previous stage's output as its
//   address MSB. Config is shifted in MSB-first through cfg_in while cen=1; the
//   first bit shifted is the output mode bit, followed by stage 0's table, then
//   stage 1's, and so on. The block only drives a function result once the full
//   CFG_BITS have been loaded (state READY).
//
//   Ports:
//     cclk     : single clock for configuration and the output register
//     rst_n    : asynchronous active-low reset
//     cen      : config shift enable; the cfg_in bit is consumed on that edge
//     cfg_in   : serial config data
//     cfg_out  : daisy-chain out, MSB of the config shift register
//     cfg_done : high while fully configured (READY)
//     addr     : user logic inputs, AW bits
//     out      : function output (combinational or registered per mode bit)
//     taps     : per-stage outputs, only with LUT_SXX_CHAIN_TAP_EN defined
//
//   Build option: define LUT_SXX_CHAIN_TAP_EN to add the taps debug port.
// -----------------------------------------------------------------------------
module lut_sxx_chain_cfg
   import lut_sxx_chain_pkg::*;
#(
   parameter int INPUTS   = 4,
   parameter int STAGES   = 2,
   parameter int MEM_SIZE = calc_mem_size(INPUTS),
   parameter int CFG_BITS = calc_cfg_bits(INPUTS, STAGES),
   parameter int AW       = calc_aw(INPUTS, STAGES)
) (
   input  logic          cclk,
   input  logic          rst_n,
   input  logic          cen,
   input  logic          cfg_in,
   output logic          cfg_out,
   output logic          cfg_done,
   input  logic [AW-1:0] addr,
   output logic          out
`ifdef LUT_SXX_CHAIN_TAP_EN
   ,
   output logic [STAGES-1:0] taps
`endif
);

   localparam int               CNT_W   = calc_cnt_w(CFG_BITS);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_BITS);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t                state_q,   state_d;
   logic [CNT_W-1:0]      cnt_q,     cnt_d;
   logic [CFG_BITS-1:0]   cfg_sr_q,  cfg_sr_d;
   logic                  out_reg_q, out_reg_d;

   logic                  ready;
   logic                  reg_out_mode;
   logic                  chain_out;

`ifdef LUT_SXX_CHAIN_TAP_EN
   logic [STAGES-1:0]     stage_bits;
`endif

   // --------------------------------------------------------------------------
   // LUT cascade
   // Each stage's output is a separate net so the chain does not form a
   // combinational loop through a shared vector.
   // --------------------------------------------------------------------------
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [INPUTS-1:0] stage_addr;
      logic              stage_out;

      if (k == 0) begin : g_first
         assign stage_addr = addr[AW-1 -: INPUTS];
      end else begin : g_next
         assign stage_addr = {g_stage[k-1].stage_out,
                              addr[AW-INPUTS-(k-1)*(INPUTS-1)-1 -: INPUTS-1]};
      end

      lut_sxx_chain_stage #(
         .INPUTS   (INPUTS),
         .MEM_SIZE (MEM_SIZE)
      ) u_stage (
         .table_i (cfg_sr_q[(STAGES-k)*MEM_SIZE-1 -: MEM_SIZE]),
         .addr_i  (stage_addr),
         .bit_o   (stage_out)
      );

`ifdef LUT_SXX_CHAIN_TAP_EN
      assign stage_bits[k] = stage_out;
`endif
   end

   assign chain_out = g_stage[STAGES-1].stage_out;

   // --------------------------------------------------------------------------
   // Load FSM: state register
   // --------------------------------------------------------------------------
   always_ff @(posedge cclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= UNCFG;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // --------------------------------------------------------------------------
   // Load FSM: next state and bit counter
   // The counter saturates at CFG_BITS; any cen while READY restarts a load.
   // --------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         UNCFG: begin
            if (cen) begin
               state_d = LOADING;
               cnt_d   = CNT_ONE;
            end
         end
         LOADING: begin
            if (cen) begin
               if (cnt_q < CNT_MAX) begin
                  cnt_d = cnt_q + CNT_ONE;
               end
               if (cnt_q >= CNT_MAX - CNT_ONE) begin
                  state_d = READY;
               end
            end
         end
         READY: begin
            if (cen) begin
               state_d = LOADING;
               cnt_d   = CNT_ONE;
            end
         end
         default: begin
            state_d = UNCFG;
            cnt_d   = '0;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Config shift register and output register
   // --------------------------------------------------------------------------
   always_ff @(posedge cclk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_sr_q  <= '0;
         out_reg_q <= 1'b0;
      end else begin
         cfg_sr_q  <= cfg_sr_d;
         out_reg_q <= out_reg_d;
      end
   end

   always_comb begin
      cfg_sr_d = cfg_sr_q;
      if (cen) begin
         cfg_sr_d = {cfg_sr_q[CFG_BITS-2:0], cfg_in};
      end
      // Held at 0 outside READY and cleared by a reconfiguration shift, so a
      // partially loaded table can never reach the registered output.
      out_reg_d = 1'b0;
      if ((state_q == READY) && !cen) begin
         out_reg_d = chain_out;
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   always_comb begin
      ready        = (state_q == READY);
      reg_out_mode = cfg_sr_q[CFG_BITS-1];
      cfg_done     = ready;
      cfg_out      = cfg_sr_q[CFG_BITS-1];
      out          = 1'b0;
      if (ready) begin
         out = reg_out_mode ? out_reg_q : chain_out;
      end
   end

`ifdef LUT_SXX_CHAIN_TAP_EN
   always_comb begin
      taps = ready ? stage_bits : '0;
   end
`endif

endmodule

// File: tb/tb_lut_sxx_chain_cfg.sv
module tb_lut_sxx_chain_cfg;

   localparam int INPUTS   = 4;
   localparam int STAGES   = 2;
   localparam int AW       = 7;
   localparam int CFG_BITS = 33;

   localparam int S_OUT  = 0;
   localparam int S_DONE = 1;
   localparam int S_COUT = 2;

   logic          cclk   = 1'b0;
   logic          rst_n  = 1'b1;
   logic          cen    = 1'b0;
   logic          cfg_in = 1'b0;
   logic [AW-1:0] addr   = '0;
   logic          cfg_out;
   logic          cfg_done;
   logic          out;
`ifdef LUT_SXX_CHAIN_TAP_EN
   logic [STAGES-1:0] taps;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   // scoreboard: expected values queued when stimulus is driven
   string tag_q[$];
   int    sig_q[$];
   logic  exp_q[$];
   // one-cycle pipeline of expected registered outputs
   logic  pipe_q[$];

   always #5 cclk = ~cclk;

   lut_sxx_chain_cfg #(
      .INPUTS (INPUTS),
      .STAGES (STAGES)
   ) dut (
      .cclk     (cclk),
      .rst_n    (rst_n),
      .cen      (cen),
      .cfg_in   (cfg_in),
      .cfg_out  (cfg_out),
      .cfg_done (cfg_done),
      .addr     (addr),
      .out      (out)
`ifdef LUT_SXX_CHAIN_TAP_EN
      ,
      .taps     (taps)
`endif
   );

   task automatic check_bit(input string tag, input logic got, input logic exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic expect_sig(input string tag, input int sig, input logic e);
      tag_q.push_back(tag);
      sig_q.push_back(sig);
      exp_q.push_back(e);
   endtask

   task automatic drain();
      while (exp_q.size() > 0) begin
         string t;
         int    s;
         logic  e;
         logic  got;
         t = tag_q.pop_front();
         s = sig_q.pop_front();
         e = exp_q.pop_front();
         case (s)
            S_OUT:   got = out;
            S_DONE:  got = cfg_done;
            default: got = cfg_out;
         endcase
         check_bit(t, got, e);
      end
   endtask

   task automatic cyc();
      @(posedge cclk);
      #1;
   endtask

   // reference: stage0 on addr[6:3], stage1 on {stage0, addr[2:0]}
   function automatic logic model(input logic [15:0] t0, input logic [15:0] t1,
                                  input logic [6:0] a);
      logic [3:0] a1;
      a1 = {t0[a[6:3]], a[2:0]};
      return t1[a1];
   endfunction

   task automatic load(input logic mode, input logic [15:0] t0,
                       input logic [15:0] t1, input int gap_pct);
      logic [CFG_BITS-1:0] v;
      v = {mode, t0, t1};
      for (int i = CFG_BITS - 1; i >= 0; i--) begin
         if (i < CFG_BITS - 1 && gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
            cen    = 1'b0;
            cfg_in = ~v[i];
            cyc();
            expect_sig("gap_done", S_DONE, 1'b0);
            expect_sig("gap_out", S_OUT, 1'b0);
            #1;
            drain();
         end
         cen    = 1'b1;
         cfg_in = v[i];
         cyc();
         cen = 1'b0;
         expect_sig("load_done", S_DONE, (i == 0));
         expect_sig("load_out", S_OUT, (i == 0 && !mode) ? model(t0, t1, addr) : 1'b0);
         #1;
         drain();
      end
   endtask

   task automatic run_comb(input logic [15:0] t0, input logic [15:0] t1);
      for (int a = 0; a < 128; a++) begin
         logic [6:0] av;
         av   = 7'(a);
         addr = av;
         expect_sig("comb_out", S_OUT, model(t0, t1, av));
         #1;
         drain();
         cyc();
      end
   endtask

   task automatic run_reg(input logic [15:0] t0, input logic [15:0] t1, input int n);
      pipe_q.delete();
      pipe_q.push_back(1'b0);
      for (int j = 0; j < n; j++) begin
         logic [6:0] av;
         av   = (j % 3 == 0) ? 7'h78 : 7'($urandom_range(127));
         addr = av;
         expect_sig("reg_out", S_OUT, pipe_q.pop_front());
         pipe_q.push_back(model(t0, t1, av));
         #1;
         drain();
         cyc();
      end
   endtask

   task automatic expect_cleared(input string tag);
      expect_sig({tag, "_out"}, S_OUT, 1'b0);
      expect_sig({tag, "_done"}, S_DONE, 1'b0);
      expect_sig({tag, "_cfgout"}, S_COUT, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [15:0] r0, r1, r2, r3;
      logic        win[$];
      int          shifts;
      int          guard;

      // power-up reset, asserted between edges
      #2 rst_n = 1'b0;
      #1;
      expect_cleared("rst");
      drain();
      for (int j = 0; j < 4; j++) begin
         cyc();
         addr = (j % 2 == 0) ? 7'h78 : 7'h7F;
         expect_sig("rst_toggle_out", S_OUT, 1'b0);
         #1;
         drain();
      end
      rst_n = 1'b1;
      for (int j = 0; j < 3; j++) begin
         cyc();
         addr = (j % 2 == 0) ? 7'h7F : 7'h78;
         expect_sig("uncfg_out", S_OUT, 1'b0);
         expect_sig("uncfg_done", S_DONE, 1'b0);
         #1;
         drain();
      end

      // combinational mode, fixed then random tables (gapped load from READY)
      addr = 7'h78;
      load(1'b0, 16'h8000, 16'hFF00, 0);
      run_comb(16'h8000, 16'hFF00);
      r0 = 16'($urandom);
      r1 = 16'($urandom);
      load(1'b0, r0, r1, 30);
      run_comb(r0, r1);

      // registered mode
      addr = 7'h78;
      load(1'b1, 16'h8000, 16'hFF00, 0);
      run_reg(16'h8000, 16'hFF00, 24);
      addr = 7'h78;
      cyc();
      expect_sig("reg_78", S_OUT, 1'b1);
      expect_sig("reg_cfgout_mode", S_COUT, 1'b1);
      #1;
      drain();

      // asynchronous reset while READY with out=1
      rst_n = 1'b0;
      #1;
      expect_cleared("rst_ready");
      drain();
      cyc();
      rst_n = 1'b1;

      // partial load then reset: the next load must be a full one
      for (int j = 0; j < 20; j++) begin
         cen    = 1'b1;
         cfg_in = 1'($urandom_range(1));
         cyc();
      end
      cen   = 1'b0;
      rst_n = 1'b0;
      #1;
      expect_cleared("rst_partial");
      drain();
      cyc();
      rst_n = 1'b1;
      r2 = 16'($urandom);
      r3 = 16'($urandom);
      load(1'b1, r2, r3, 0);
      run_reg(r2, r3, 24);

      // reconfiguration from READY: first shift drops cfg_done and out
      addr = 7'h78;
      load(1'b0, 16'h8000, 16'hFF00, 0);

      // daisy chain with random gaps
      cyc();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      shifts = 0;
      guard  = 0;
      while (shifts < 66 && guard < 400) begin
         logic b;
         logic do_shift;
         guard++;
         do_shift = ($urandom_range(3) != 0);
         b        = 1'($urandom_range(1));
         cen      = do_shift;
         cfg_in   = b;
         cyc();
         cen = 1'b0;
         if (do_shift) begin
            win.push_back(b);
            shifts++;
            if (win.size() > CFG_BITS) begin
               void'(win.pop_front());
            end
         end
         expect_sig("daisy", S_COUT, (win.size() == CFG_BITS) ? win[0] : 1'b0);
         #1;
         drain();
      end
      check_bit("daisy_len", (shifts == 66), 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lut_sxx_chain_cfg.md
Name: lut_sxx_chain_cfg

Overview:
- Parametrised successor to the two-stage split LUT: STAGES cascaded INPUTS-input LUTs.
- Each stage after the first takes the previous stage's output as its address MSB.
- Adds an on-block serial configuration loader (shift register, bit counter, load FSM), a daisy-chain config output, and an optional registered-output mode held in config.
- Sits in the CLB slice wherever wide cascaded logic functions are mapped.

Parameters:
- INPUTS, 4, address bits per stage LUT (≥2).
- STAGES, 2, number of cascaded LUT stages (≥1).
- MEM_SIZE, 2**INPUTS, truth-table bits per stage (derived; do not override).
- CFG_BITS, STAGES*MEM_SIZE+1, total config bits: tables plus 1 mode bit (derived).
- AW, STAGES*(INPUTS-1)+1, user address width (derived; equals 7 at defaults).

Ports:
- cclk, in, 1, single clock, used for both config and output register.
- rst_n, in, 1, asynchronous active-low reset.
- cen, in, 1, config shift enable.
- cfg_in, in, 1, serial config data.
- cfg_out, out, 1, serial config daisy-chain out (MSB of shift register).
- cfg_done, out, 1, high when block is fully configured (state READY).
- addr, in, AW, user logic inputs.
- out, out, 1, function output.

Behaviour:
- Reset (rst_n=0, async):
  - Shift register, bit counter, output register and state all clear.
  - State becomes UNCFG; out=0, cfg_done=0, cfg_out=0.
- Shift: on cclk rising with cen=1, cfg_sr <= {cfg_sr[CFG_BITS-2:0], cfg_in}; cfg_out = cfg_sr[CFG_BITS-1] (registered).
- Counter: $clog2(CFG_BITS+1) bits, saturating at CFG_BITS, never wraps.
- FSM:
  - UNCFG: cen=1 -> LOADING, count=1.
  - LOADING: each cen=1 increments count. The cycle whose shift makes count==CFG_BITS moves to READY; cfg_done is high from the next edge.
  - READY: cen=1 -> LOADING with count=1 (reconfiguration restarts). cen=0 holds.
  - cen=0 in LOADING holds state and count (gapped loading allowed).
- Config map, valid in READY:
  - Mode bit = cfg_sr[CFG_BITS-1], the first bit shifted. REG_OUT=1 selects the registered output.
  - Stage k table = cfg_sr[(STAGES-k)*MEM_SIZE-1 -: MEM_SIZE]. Stage 0 is shifted first after the mode bit.
- Addressing:
  - Stage 0 address = addr[AW-1 -: INPUTS].
  - Stage k≥1 address = {out_{k-1}, addr[AW-INPUTS-(k-1)*(INPUTS-1)-1 -: INPUTS-1]}.
  - Stage output = table_k[address_k].
- Output:
  - Whenever state != READY, out is forced to 0 and the output register is held at 0.
  - REG_OUT=0: out = out_{STAGES-1} combinationally; zero cycles of latency.
  - REG_OUT=1: out register loads out_{STAGES-1} every cclk edge with cen=0 in READY; one cycle of latency.
- Simultaneous events:
  - cen=1 in READY with REG_OUT=1: the register clears to 0 on the same edge.
  - Reset mid-load discards partial data; no partial table is ever observable on out.
- No handshake beyond cen. The bit presented on cfg_in at an edge with cen=1 is consumed on that edge.

Optional Feature:
- Macro: LUT_SXX_CHAIN_TAP_EN.
- Defined:
  - Adds output port taps [STAGES-1:0], where taps[k] = out_k (combinational stage outputs).
  - taps are forced to 0 when state != READY.
  - Used for debug and fast carry-style tapping.
- Undefined: the port and its gating logic are absent; all other behaviour is identical.

Decomposition:
- Package lut_sxx_chain_pkg holds:
  - the state enum (UNCFG, LOADING, READY);
  - width helper functions for AW, CFG_BITS and the counter width.
- Sub-module lut_sxx_chain_stage: one purely combinational INPUTS-input table lookup (table, addr -> bit), instantiated STAGES times in a generate loop.
- FSM, counter, shift register and output register live in the top module.

Test Plan (defaults INPUTS=4, STAGES=2, CFG_BITS=33):
- Reset: assert rst_n=0 mid-cycle -> out=0, cfg_done=0, cfg_out=0 immediately; a toggling addr leaves out at 0.
- Load mode=0, stage0=16'h8000, stage1=16'hFF00 (33 cen cycles) -> cfg_done rises after the 33rd edge; out=1 only for addr[6:3]=4'hF, independent of addr[2:0].
- Same tables with mode=1 -> out follows addr one cclk later; addr=7'h78 at edge n gives out=1 after edge n.
- 20 shifts, then pulse rst_n low -> UNCFG, count=0; a subsequent full 33-bit load is required before cfg_done=1.
- In READY, one cen=1 cycle -> cfg_done=0 and out=0 the next cycle; 32 further shifts restore READY.
- Daisy chain: random 66-bit stream -> cfg_out equals cfg_in delayed by exactly 33 cen cycles, and gaps with cen=0 do not alter the sequence.
